// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Drives the program counter to a synchronous instruction memory (data returns
// one cycle after its address), and presents each returned word together with
// its PC and redirect tag. A taken jump bumps the tag so downstream stages can
// drop wrong-path words. A downstream hold is absorbed by a one-entry skid
// register holding the word that was in flight when the hold arrived.
//
// Ports:
//   clk                  pipeline clock
//   reset                asynchronous, active-low reset
//   hold                 downstream stall; outputs frozen while 1
//   jump / jump_target   taken redirect from execute (target bits [1:0] ignored)
//   instruction_address  address to instruction memory (the pc register)
//   instruction_in       memory read data for the previous cycle's address
//   instruction/NPC/tag_out/valid  fetched word, its address, its tag, qualifier
//
// Optional build macro FETCH_COUNTERS_EN adds fetch_count / bubble_count.

module fetch_unit #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction_in,
    output logic [31:0] instruction,
    output logic [31:0] NPC,
    output logic [3:0]  tag_out,
    output logic        valid
`ifdef FETCH_COUNTERS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    // EMPTY: nothing valid in flight; RUN: word in flight on instruction_in;
    // STALL: the in-flight word has been parked in skid.
    typedef enum logic [1:0] {EMPTY, RUN, STALL} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, f_pc, skid;
    logic [3:0]  tag, f_tag;
    logic        load_word, load_bubble, cap_skid, use_skid;

    assign instruction_address = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Priority: jump > hold > advance.
    always_comb begin
        state_nxt   = state;
        load_word   = 1'b0;
        load_bubble = 1'b0;
        cap_skid    = 1'b0;
        use_skid    = 1'b0;
        if (jump) begin
            state_nxt   = EMPTY;
            load_bubble = 1'b1;
        end else if (hold) begin
            // Only RUN has a live word on instruction_in that would be lost.
            if (state == RUN) begin
                state_nxt = STALL;
                cap_skid  = 1'b1;
            end
        end else begin
            state_nxt = RUN;
            case (state)
                RUN:     load_word = 1'b1;
                STALL: begin
                    load_word = 1'b1;
                    use_skid  = 1'b1;
                end
                default: load_bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= START_ADDR;
            tag         <= 4'd0;
            f_pc        <= 32'd0;
            f_tag       <= 4'd0;
            skid        <= 32'd0;
            instruction <= 32'd0;
            NPC         <= 32'd0;
            tag_out     <= 4'd0;
            valid       <= 1'b0;
        end else begin
            if (jump) begin
                pc  <= {jump_target[31:2], 2'b00};
                tag <= tag + 4'd1;
            end else if (!hold) begin
                // While held, pc stays put so memory keeps re-reading the word
                // that follows the skid word.
                pc    <= pc + 32'd4;
                f_pc  <= pc;
                f_tag <= tag;
            end
            if (cap_skid) skid <= instruction_in;
            if (load_word) begin
                instruction <= use_skid ? skid : instruction_in;
                NPC         <= f_pc;
                tag_out     <= f_tag;
                valid       <= 1'b1;
            end else if (load_bubble) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_COUNTERS_EN
    // A jump under hold clears valid but is not counted as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (load_word)              fetch_count  <= fetch_count + 32'd1;
            if (load_bubble && !hold)   bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural synchronous memory feeds the
// DUT, expected words are queued as each scenario is set up and popped by a
// monitor whenever a new word is loaded onto the outputs.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, hold, jump;
    logic [31:0] jump_target;
    logic [31:0] instruction_address;
    logic [31:0] instruction_in = 32'd0;
    logic [31:0] instruction, NPC;
    logic [3:0]  tag_out;
    logic        valid;
`ifdef FETCH_COUNTERS_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] ins;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    logic last_hold = 1'b0;
    logic last_jump = 1'b0;

    fetch_unit #(.START_ADDR(32'h0000_0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .hold                (hold),
        .jump                (jump),
        .jump_target         (jump_target),
        .instruction_address (instruction_address),
        .instruction_in      (instruction_in),
        .instruction         (instruction),
        .NPC                 (NPC),
        .tag_out             (tag_out),
        .valid               (valid)
`ifdef FETCH_COUNTERS_EN
        ,
        .fetch_count         (fetch_count),
        .bubble_count        (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory: data one cycle after its address.
    always @(posedge clk) instruction_in <= mem_word(instruction_address);

    always @(posedge clk) begin
        last_hold = hold;
        last_jump = jump;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] npc, input logic [3:0] tg);
        exp_t e;
        e.npc = npc;
        e.ins = mem_word(npc);
        e.tag = tg;
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A new word is loaded only on an edge that saw neither hold nor jump.
    always @(negedge clk) begin
        if (reset && valid && !last_hold && !last_jump) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed NPC %h expected no word", NPC);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_npc", NPC, e.npc);
                chk("sb_instruction", instruction, e.ins);
                chk("sb_tag", {28'd0, tag_out}, {28'd0, e.tag});
            end
        end
    end

    initial begin
        reset = 1'b0;
        hold = 1'b0;
        jump = 1'b0;
        jump_target = 32'd0;
        #12;
        chk("rst_addr", instruction_address, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_npc", NPC, 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_tag", {28'd0, tag_out}, 32'd0);

        // Straight-line fetch from reset.
        push(32'h00, 4'd0); push(32'h04, 4'd0); push(32'h08, 4'd0);
        push(32'h0C, 4'd0); push(32'h10, 4'd0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("first_edge_bubble", {31'd0, valid}, 32'd0);
        step(5);
        chk("stream_npc_0x10", NPC, 32'h10);
`ifdef FETCH_COUNTERS_EN
        chk("fetch_count", fetch_count, 32'd5);
        chk("bubble_count", bubble_count, 32'd1);
`endif

        // Three-cycle hold: outputs frozen, then skid word first.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_npc", NPC, 32'h10);
            chk("hold_instruction", instruction, mem_word(32'h10));
            chk("hold_valid", {31'd0, valid}, 32'd1);
        end
        hold = 1'b0;
        push(32'h14, 4'd0); push(32'h18, 4'd0); push(32'h1C, 4'd0);
        step(3);

        // Redirect with unaligned target.
        jump = 1'b1;
        jump_target = 32'h0000_0103;
        push(32'h100, 4'd1); push(32'h104, 4'd1);
        step();
        jump = 1'b0;
        chk("jump_addr", instruction_address, 32'h100);
        chk("jump_bubble1", {31'd0, valid}, 32'd0);
        step();
        chk("jump_bubble2", {31'd0, valid}, 32'd0);
        step(2);

        // Jump while stalled: skid dropped, target fetched with new tag.
        hold = 1'b1;
        step();
        chk("stall_npc", NPC, 32'h104);
        jump = 1'b1;
        jump_target = 32'h0000_0200;
        push(32'h200, 4'd2);
        step();
        chk("stall_jump_valid", {31'd0, valid}, 32'd0);
        chk("stall_jump_addr", instruction_address, 32'h200);
        hold = 1'b0;
        jump = 1'b0;
        step();
        chk("stall_jump_bubble", {31'd0, valid}, 32'd0);
        step();

        // 16 back-to-back jumps: tag wraps back to 2; then pc wraps to 0.
        jump = 1'b1;
        jump_target = 32'hFFFF_FFF8;
        for (int i = 0; i < 16; i++) step();
        jump = 1'b0;
        push(32'hFFFF_FFF8, 4'd2); push(32'hFFFF_FFFC, 4'd2);
        push(32'h0, 4'd2);         push(32'h4, 4'd2);
        step();
        step();
        chk("pc_wrap", instruction_address, 32'h0);
        step(3);

        // Asynchronous reset in the middle of a stall.
        hold = 1'b1;
        step();
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_npc", NPC, 32'd0);
        chk("arst_instruction", instruction, 32'd0);
        chk("arst_tag", {28'd0, tag_out}, 32'd0);
        chk("arst_addr", instruction_address, 32'h0);
`ifdef FETCH_COUNTERS_EN
        chk("arst_fetch_count", fetch_count, 32'd0);
        chk("arst_bubble_count", bubble_count, 32'd0);
`endif
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
